// File: rtl/ram_access_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: round-robin with burst lock,
// one access per cycle, read data returned one cycle after grant with a per-port valid.
module ram_access_arbiter #(
  parameter int width      = 8,
  parameter int depth_bits = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_lock,
  input  logic                  a_we,
  input  logic [depth_bits-1:0] a_addr,
  input  logic [width-1:0]      a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [width-1:0]      a_rdata,
  input  logic                  b_req,
  input  logic                  b_lock,
  input  logic                  b_we,
  input  logic [depth_bits-1:0] b_addr,
  input  logic [width-1:0]      b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [width-1:0]      b_rdata,
  output logic                  ram_write_en,
  output logic [depth_bits-1:0] ram_write_address,
  output logic [width-1:0]      ram_write_data_in,
  output logic                  ram_read_en,
  output logic [depth_bits-1:0] ram_read_address,
  input  logic [width-1:0]      ram_read_data_out
);

  typedef enum logic [1:0] {FREE, OWN_A, OWN_B} owner_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_A, TAG_B} tag_t;

  typedef struct packed {
    logic                  req;
    logic                  lock;
    logic                  we;
    logic [depth_bits-1:0] addr;
    logic [width-1:0]      wdata;
  } port_req_t;

  owner_t    owner_q, owner_d;
  logic      prio_q, prio_d;
  tag_t      rd_tag_q, rd_tag_d;
  logic      gnt_a, gnt_b;
  port_req_t pa, pb, sel;

  assign pa = '{req: a_req, lock: a_lock, we: a_we, addr: a_addr, wdata: a_wdata};
  assign pb = '{req: b_req, lock: b_lock, we: b_we, addr: b_addr, wdata: b_wdata};

  // An owner that stops requesting behaves as if the RAM were free.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      if (owner_q == OWN_A && pa.req)      gnt_a = 1'b1;
      else if (owner_q == OWN_B && pb.req) gnt_b = 1'b1;
      else if (pa.req && pb.req) begin
        gnt_a = !prio_q;
        gnt_b = prio_q;
      end
      else if (pa.req)                     gnt_a = 1'b1;
      else if (pb.req)                     gnt_b = 1'b1;
    end
  end

  assign a_gnt = gnt_a;
  assign b_gnt = gnt_b;

  // Pins follow A whenever B is not the granted port.
  assign sel               = gnt_b ? pb : pa;
  assign ram_write_address = sel.addr;
  assign ram_read_address  = sel.addr;
  assign ram_write_data_in = sel.wdata;
  assign ram_write_en      = (gnt_a || gnt_b) && sel.we;
  assign ram_read_en       = (gnt_a || gnt_b) && !sel.we;

  always_comb begin
    owner_d  = FREE;
    prio_d   = prio_q;
    rd_tag_d = TAG_NONE;
    if (gnt_a) begin
      if (pa.lock) owner_d = OWN_A;
      else         prio_d  = 1'b1;
      if (!pa.we)  rd_tag_d = TAG_A;
    end
    else if (gnt_b) begin
      if (pb.lock) owner_d = OWN_B;
      else         prio_d  = 1'b0;
      if (!pb.we)  rd_tag_d = TAG_B;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= FREE;
      prio_q   <= 1'b0;
      rd_tag_q <= TAG_NONE;
    end
    else begin
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  assign a_rvalid = (rd_tag_q == TAG_A);
  assign b_rvalid = (rd_tag_q == TAG_B);
  assign a_rdata  = ram_read_data_out;
  assign b_rdata  = ram_read_data_out;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: behavioural RAM, shadow-memory scoreboard of expected read returns,
// directed scenarios and a random mix checked against an independent arbitration model.
module tb_ram_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_lock, a_we, b_req, b_lock, b_we;
  logic [1:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_write_en, ram_read_en;
  logic [1:0] ram_write_address, ram_read_address;
  logic [7:0] ram_write_data_in;
  logic [7:0] ram_rdout = 8'h00;
  logic [7:0] mem [4] = '{default: 8'h00};
  logic [7:0] shadow [4];

  int checks = 0;
  int errors = 0;
  logic last_ga, last_gb;

  typedef struct {
    logic       port;   // 0 = A, 1 = B
    logic [7:0] data;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  ram_access_arbiter #(.width(8), .depth_bits(2)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_write_en(ram_write_en), .ram_write_address(ram_write_address),
    .ram_write_data_in(ram_write_data_in), .ram_read_en(ram_read_en),
    .ram_read_address(ram_read_address), .ram_read_data_out(ram_rdout)
  );

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_address] <= ram_write_data_in;
    if (ram_read_en)  ram_rdout <= mem[ram_read_address];
  end

  // One cycle: inputs already set at the negedge; checks returns, records grants, waits for next negedge.
  task automatic step();
    sb_t e;
    #1;
    checks++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if ({a_rvalid, b_rvalid} !== (e.port ? 2'b01 : 2'b10) ||
          (e.port ? b_rdata : a_rdata) !== e.data) begin
        errors++;
        $display("FAIL rdata_return: a_rvalid=%b b_rvalid=%b rdata=%h, required port=%s data=%h",
                 a_rvalid, b_rvalid, e.port ? b_rdata : a_rdata, e.port ? "B" : "A", e.data);
      end
    end
    else if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_rvalid: a_rvalid=%b b_rvalid=%b, required 0 0", a_rvalid, b_rvalid);
    end
    checks++;
    if ((ram_write_en & ram_read_en) !== 1'b0 || (a_gnt & b_gnt) !== 1'b0) begin
      errors++;
      $display("FAIL exclusive: we=%b re=%b a_gnt=%b b_gnt=%b, required never two at once",
               ram_write_en, ram_read_en, a_gnt, b_gnt);
    end
    last_ga = a_gnt;
    last_gb = b_gnt;
    if (a_gnt) begin
      if (a_we) shadow[a_addr] = a_wdata;
      else sb_q.push_back('{port: 1'b0, data: shadow[a_addr]});
    end
    if (b_gnt) begin
      if (b_we) shadow[b_addr] = b_wdata;
      else sb_q.push_back('{port: 1'b1, data: shadow[b_addr]});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_req = 1'b1; a_lock = 1'b0; a_we = 1'b1; a_addr = 2'd0; a_wdata = 8'h5A;
    b_req = 1'b1; b_lock = 1'b0; b_we = 1'b0; b_addr = 2'd0; b_wdata = 8'h00;
    @(negedge clk);
    #1;
    checks++;
    if ({a_gnt, b_gnt, ram_write_en, ram_read_en, a_rvalid, b_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b we=%b re=%b rvalid=%b%b, required all 0",
               a_gnt, b_gnt, ram_write_en, ram_read_en, a_rvalid, b_rvalid);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({last_ga, last_gb} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_grant: a=%b b=%b, required A first", last_ga, last_gb);
    end
    a_req = 1'b0;
    step();
    checks++;
    if (last_gb !== 1'b1) begin
      errors++;
      $display("FAIL reset_b_next: b_gnt=%b, required 1", last_gb);
    end
    b_req = 1'b0;
    step();
  endtask

  task automatic test_write_then_read();
    a_req = 1'b1; a_we = 1'b1; a_addr = 2'd2; a_wdata = 8'hA5;
    step();
    checks++;
    if (last_ga !== 1'b1) begin
      errors++;
      $display("FAIL wr_grant: a_gnt=%b, required 1", last_ga);
    end
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 2'd2;
    step();
    checks++;
    if (last_gb !== 1'b1) begin
      errors++;
      $display("FAIL rd_grant: b_gnt=%b, required 1", last_gb);
    end
    b_req = 1'b0;
    #1;
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 8'hA5 || a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_after_wr: b_rvalid=%b b_rdata=%h a_rvalid=%b, required 1 a5 0",
               b_rvalid, b_rdata, a_rvalid);
    end
    step();
  endtask

  task automatic test_alternate();
    logic exp_a = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_lock = 1'b0; a_addr = 2'd0; a_wdata = 8'hC0;
    b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = 2'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({last_ga, last_gb} !== {exp_a, !exp_a}) begin
        errors++;
        $display("FAIL alternate[%0d]: a=%b b=%b, required a=%b b=%b", i, last_ga, last_gb, exp_a, !exp_a);
      end
      if (last_ga) begin a_addr = a_addr + 2'd1; a_wdata = a_wdata + 8'h01; end
      if (last_gb) b_addr = b_addr + 2'd1;
      exp_a = !exp_a;
    end
    a_req = 1'b0; b_req = 1'b0;
    step();
  endtask

  task automatic test_lock_burst();
    logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    a_req = 1'b1; a_we = 1'b1; a_lock = 1'b1;
    b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = 2'd3;
    for (int i = 0; i < 4; i++) begin
      a_addr = 2'(i); a_wdata = dat[i];
      step();
      checks++;
      if ({last_ga, last_gb} !== 2'b10) begin
        errors++;
        $display("FAIL lock_burst[%0d]: a=%b b=%b, required A only", i, last_ga, last_gb);
      end
    end
    a_req = 1'b0; a_lock = 1'b0;
    step();
    checks++;
    if (last_gb !== 1'b1) begin
      errors++;
      $display("FAIL lock_release: b_gnt=%b, required 1", last_gb);
    end
    b_req = 1'b0;
    #1;
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 8'h44) begin
      errors++;
      $display("FAIL lock_readback: b_rvalid=%b b_rdata=%h, required 1 44", b_rvalid, b_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    a_req = 1'b1; a_we = 1'b1; a_lock = 1'b0; a_addr = 2'd1; a_wdata = 8'h77;
    b_req = 1'b0;
    step();
    a_we = 1'b0; a_lock = 1'b1;
    #1;
    checks++;
    if (a_gnt !== 1'b1 || ram_read_en !== 1'b1) begin
      errors++;
      $display("FAIL midrd_grant: a_gnt=%b re=%b, required 1 1", a_gnt, ram_read_en);
    end
    #2 reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrd_no_rvalid: a_rvalid=%b b_rvalid=%b, required 0 0", a_rvalid, b_rvalid);
    end
    reset = 1'b0;
    a_we = 1'b1; a_lock = 1'b0; a_addr = 2'd2; a_wdata = 8'h99;
    b_req = 1'b1; b_we = 1'b1; b_addr = 2'd3; b_wdata = 8'h66;
    step();
    checks++;
    if ({last_ga, last_gb} !== 2'b10) begin
      errors++;
      $display("FAIL midrd_prio: a=%b b=%b, required A (prio cleared)", last_ga, last_gb);
    end
    a_req = 1'b0;
    step();
    b_req = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [1:0] own;
    logic       prio, ea, eb;
    reset = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    step();
    reset = 1'b0;
    own = 2'd0; prio = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!a_req || last_ga) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
        a_lock = ($urandom_range(0, 3) == 0); a_addr = 2'($urandom_range(0, 3));
        a_wdata = 8'($urandom_range(0, 255));
      end
      if (!b_req || last_gb) begin
        b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1));
        b_lock = ($urandom_range(0, 3) == 0); b_addr = 2'($urandom_range(0, 3));
        b_wdata = 8'($urandom_range(0, 255));
      end
      ea = a_req && (own == 2'd1 || !(own == 2'd2 && b_req) && (!b_req || !prio));
      eb = b_req && !ea;
      step();
      checks++;
      if ({last_ga, last_gb} !== {ea, eb}) begin
        errors++;
        $display("FAIL rand_grant[%0d]: a=%b b=%b, required a=%b b=%b", i, last_ga, last_gb, ea, eb);
      end
      if (ea) begin own = a_lock ? 2'd1 : 2'd0; if (!a_lock) prio = 1'b1; end
      else if (eb) begin own = b_lock ? 2'd2 : 2'd0; if (!b_lock) prio = 1'b0; end
      else own = 2'd0;
    end
    a_req = 1'b0; b_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) shadow[i] = 8'h00;
    test_reset();
    test_write_then_read();
    test_alternate();
    test_lock_burst();
    test_reset_mid_read();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d returns outstanding, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
